// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs a one-outstanding sram-like instruction port,
// and hands fetched instructions to IF/ID with branch (post delay slot) and exception redirects.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        flush_excM,
  input  logic [31:0] pc_excM,
  input  logic        branch_redirectD,
  input  logic [31:0] branch_targetD,
  input  logic        is_branch_jumpD,
  input  logic        inst_tlb_refill_i,
  input  logic        inst_tlb_invalid_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
  output logic        is_in_delayslot_iF,
  output logic        inst_tlb_refillF,
  output logic        inst_tlb_invalidF,
  output logic        validF,
  output logic        i_stall
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pc4, w_pc4_nxt;
  logic [XLEN-1:0] r_instr, w_instr_nxt;
  logic [XLEN-1:0] r_br_tgt, w_br_tgt_nxt;
  logic [XLEN-1:0] r_exc_tgt, w_exc_tgt_nxt;
  logic            r_refill, w_refill_nxt;
  logic            r_invalid, w_invalid_nxt;
  logic            r_pend_br, w_pend_br_nxt;
  logic            r_pend_exc, w_pend_exc_nxt;
  logic            r_discard, w_discard_nxt;

  logic            w_fault;
  logic            w_valid;
  logic            w_handoff;
  logic            w_req;
  logic [XLEN-1:0] w_next_pc;

  assign w_fault   = inst_tlb_refill_i | inst_tlb_invalid_i;
  assign w_valid   = (r_state == S_DONE);
  assign w_handoff = w_valid & ~stallF;
  assign w_req     = (r_state == S_REQ) & ~w_fault & ~rst;

  // Redirect priority: live exception, pending exception, branch, sequential
  assign w_next_pc = flush_excM                   ? pc_excM   :
                     r_pend_exc                   ? r_exc_tgt :
                     branch_redirectD             ? branch_targetD :
                     r_pend_br                    ? r_br_tgt  :
                                                    r_pc4;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pc4_nxt      = r_pc4;
    w_instr_nxt    = r_instr;
    w_br_tgt_nxt   = r_br_tgt;
    w_exc_tgt_nxt  = r_exc_tgt;
    w_refill_nxt   = r_refill;
    w_invalid_nxt  = r_invalid;
    w_pend_br_nxt  = r_pend_br;
    w_pend_exc_nxt = r_pend_exc;
    w_discard_nxt  = r_discard;

    // A taken branch waits for its delay slot to be handed off first
    if (flush_excM) begin
      w_pend_br_nxt = 1'b0;
    end else if (branch_redirectD && !w_handoff) begin
      w_pend_br_nxt = 1'b1;
      w_br_tgt_nxt  = branch_targetD;
    end

    unique case (r_state)
      S_REQ: begin
        if (w_fault) begin
          if (flush_excM || r_pend_exc) begin
            w_pc_nxt       = w_next_pc;
            w_pc4_nxt      = w_next_pc + PC_STEP;
            w_pend_exc_nxt = 1'b0;
          end else begin
            w_refill_nxt  = inst_tlb_refill_i;
            w_invalid_nxt = inst_tlb_invalid_i;
            w_instr_nxt   = '0;
            w_state_nxt   = S_DONE;
          end
        end else if (flush_excM) begin
          // Address must stay put until accepted; the reply is dropped afterwards
          w_pend_exc_nxt = 1'b1;
          w_exc_tgt_nxt  = pc_excM;
          if (inst_addr_ok) begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = S_WAIT;
          end
        end else if (inst_addr_ok) begin
          if (r_pend_exc) begin
            w_discard_nxt = 1'b1;
          end
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush_excM) begin
          w_pend_exc_nxt = 1'b1;
          w_exc_tgt_nxt  = pc_excM;
          w_discard_nxt  = 1'b1;
        end
        if (inst_data_ok) begin
          if (r_discard || flush_excM) begin
            w_pc_nxt       = w_next_pc;
            w_pc4_nxt      = w_next_pc + PC_STEP;
            w_discard_nxt  = 1'b0;
            w_pend_exc_nxt = 1'b0;
            w_state_nxt    = S_REQ;
          end else begin
            w_instr_nxt = inst_rdata;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (flush_excM || w_handoff) begin
          w_pc_nxt       = w_next_pc;
          w_pc4_nxt      = w_next_pc + PC_STEP;
          w_instr_nxt    = '0;
          w_refill_nxt   = 1'b0;
          w_invalid_nxt  = 1'b0;
          w_pend_exc_nxt = 1'b0;
          w_state_nxt    = S_REQ;
          if (w_handoff) begin
            w_pend_br_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc4      <= RESET_PC + PC_STEP;
      r_instr    <= '0;
      r_br_tgt   <= '0;
      r_exc_tgt  <= '0;
      r_refill   <= 1'b0;
      r_invalid  <= 1'b0;
      r_pend_br  <= 1'b0;
      r_pend_exc <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_pc4      <= w_pc4_nxt;
      r_instr    <= w_instr_nxt;
      r_br_tgt   <= w_br_tgt_nxt;
      r_exc_tgt  <= w_exc_tgt_nxt;
      r_refill   <= w_refill_nxt;
      r_invalid  <= w_invalid_nxt;
      r_pend_br  <= w_pend_br_nxt;
      r_pend_exc <= w_pend_exc_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  assign inst_req           = w_req;
  assign inst_addr          = r_pc;
  assign pcF                = r_pc;
  assign pc_plus4F          = r_pc4;
  assign instrF             = r_instr;
  assign inst_tlb_refillF   = r_refill;
  assign inst_tlb_invalidF  = r_invalid;
  assign validF             = w_valid;
  assign i_stall            = ~w_valid;
  assign is_in_delayslot_iF = is_branch_jumpD & w_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: random memory/pipeline environment, program-flow reference model
// feeding an expected-delivery queue, and an independent hand-off monitor.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        flush_excM;
  logic [31:0] pc_excM;
  logic        branch_redirectD;
  logic [31:0] branch_targetD;
  logic        is_branch_jumpD;
  logic        inst_tlb_refill_i;
  logic        inst_tlb_invalid_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic [31:0] instrF;
  logic        is_in_delayslot_iF;
  logic        inst_tlb_refillF;
  logic        inst_tlb_invalidF;
  logic        validF;
  logic        i_stall;

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .flush_excM(flush_excM), .pc_excM(pc_excM),
    .branch_redirectD(branch_redirectD), .branch_targetD(branch_targetD),
    .is_branch_jumpD(is_branch_jumpD), .inst_tlb_refill_i(inst_tlb_refill_i),
    .inst_tlb_invalid_i(inst_tlb_invalid_i), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .pcF(pcF), .pc_plus4F(pc_plus4F), .instrF(instrF), .is_in_delayslot_iF(is_in_delayslot_iF),
    .inst_tlb_refillF(inst_tlb_refillF), .inst_tlb_invalidF(inst_tlb_invalidF),
    .validF(validF), .i_stall(i_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        refill;
    logic        invalid;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_ho = 0;
  int          idle = 0;
  int          stall_cnt = 0;
  bit          fast = 1'b1;
  bit          quiet = 1'b1;
  bit          mon_en = 1'b0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [31:0] m_cur = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc3a5_5a3c;
  endfunction

  function automatic logic f_refill(input logic [31:0] a);
    return (a[7:2] == 6'h15) || (a[7:2] == 6'h3f);
  endfunction

  function automatic logic f_invalid(input logic [31:0] a);
    return (a[7:2] == 6'h2a) || (a[7:2] == 6'h3f);
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc      = pc;
    e.refill  = f_refill(pc);
    e.invalid = f_invalid(pc);
    e.instr   = (e.refill || e.invalid) ? 32'd0 : mem_word(pc);
    return e;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return 32'hffff_fff0 | (r & 32'h0000_000c);
      1:       return {24'h004000, r[7:2], 2'b00};
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  assign inst_tlb_refill_i  = f_refill(inst_addr);
  assign inst_tlb_invalid_i = f_invalid(inst_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of environment + reference model; called at a negedge
  task automatic drive();
    logic        ho;
    logic [31:0] nxt;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom();
    if (mem_busy) begin
      if (fast || $urandom_range(0, 2) == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(mem_addr);
        mem_busy     = 1'b0;
      end
    end else if (!fast && $urandom_range(0, 7) == 0) begin
      inst_data_ok = 1'b1;
    end
    inst_addr_ok = fast ? 1'b1 : 1'($urandom_range(0, 2) != 0);
    if (stall_cnt > 0) begin
      stallF = 1'b1;
      stall_cnt--;
    end else begin
      stallF = fast ? 1'b0 : 1'($urandom_range(0, 99) < 30);
    end
    flush_excM       = 1'b0;
    branch_redirectD = 1'b0;
    is_branch_jumpD  = 1'($urandom_range(0, 1));
    branch_targetD   = rand_pc();
    pc_excM          = ($urandom_range(0, 1) == 0) ? 32'hbfc0_0380 : rand_pc();
    if (!quiet) begin
      flush_excM       = 1'($urandom_range(0, 99) < 4);
      branch_redirectD = 1'($urandom_range(0, 99) < 10);
      if (validF && !stallF && $urandom_range(0, 99) < 10) begin
        flush_excM       = 1'b1;
        branch_redirectD = 1'b1;
      end
    end
    #1;
    if (inst_req && inst_addr_ok) begin
      mem_busy = 1'b1;
      mem_addr = inst_addr;
    end
    ho = validF && !stallF;
    if (flush_excM) begin
      exp_q.delete();
      exp_q.push_back(mk(pc_excM));
      m_cur  = pc_excM;
      m_pend = 1'b0;
    end else begin
      if (branch_redirectD) begin
        m_pend = 1'b1;
        m_tgt  = branch_targetD;
      end
      if (ho) begin
        nxt    = m_pend ? m_tgt : m_cur + 32'd4;
        m_pend = 1'b0;
        m_cur  = nxt;
        exp_q.push_back(mk(nxt));
      end
    end
  endtask

  // Monitor: samples just before each posedge, checks hand-offs and hold properties
  bit          prev_hold = 1'b0;
  bit          prev_nak = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_addr = '0;

  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (mon_en) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(validF), 32'd1);
        chk("hold_pc", pcF, prev_pc);
        chk("hold_instr", instrF, prev_instr);
      end
      if (prev_nak && inst_req) chk("addr_stable", inst_addr, prev_addr);
      if (validF) chk("no_req_when_valid", 32'(inst_req), 32'd0);
      if (validF && !stallF && !flush_excM) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL handoff_unexpected actual_pc=%h required=none t=%0t", pcF, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pcF", pcF, e.pc);
          chk("pc_plus4F", pc_plus4F, e.pc + 32'd4);
          chk("instrF", instrF, e.instr);
          chk("tlb_refillF", 32'(inst_tlb_refillF), 32'(e.refill));
          chk("tlb_invalidF", 32'(inst_tlb_invalidF), 32'(e.invalid));
          chk("delayslot", 32'(is_in_delayslot_iF), 32'(is_branch_jumpD));
          chk("i_stall", 32'(i_stall), 32'd0);
        end
        n_ho++;
        idle = 0;
      end else begin
        idle++;
        if (idle == 400) begin
          checks++;
          failures++;
          $display("FAIL watchdog actual=no_handoff_400_cycles required=handoff t=%0t", $time);
        end
      end
      prev_hold  = validF && stallF && !flush_excM;
      prev_pc    = pcF;
      prev_instr = instrF;
      prev_nak   = inst_req && !inst_addr_ok;
      prev_addr  = inst_addr;
    end
  end

  initial begin
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    rst = 1'b1;
    stallF = 1'b0; flush_excM = 1'b0; pc_excM = '0;
    branch_redirectD = 1'b0; branch_targetD = '0; is_branch_jumpD = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pcF", pcF, RESET_PC);
      chk("rst_pc_plus4F", pc_plus4F, 32'hbfc0_0004);
      chk("rst_instrF", instrF, 32'd0);
      chk("rst_validF", 32'(validF), 32'd0);
      chk("rst_i_stall", 32'(i_stall), 32'd1);
      chk("rst_inst_req", 32'(inst_req), 32'd0);
      chk("rst_flags", 32'({inst_tlb_refillF, inst_tlb_invalidF}), 32'd0);
    end

    // First fetch at minimum latency
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(RESET_PC));
    m_cur = RESET_PC;
    mon_en = 1'b1;
    drive();
    chk("first_req", 32'(inst_req), 32'd1);
    chk("first_addr", inst_addr, RESET_PC);
    @(negedge clk);
    chk("lat_valid_early", 32'(validF), 32'd0);
    drive();
    @(negedge clk);
    chk("lat_valid", 32'(validF), 32'd1);
    chk("lat_pcF", pcF, RESET_PC);
    chk("lat_instrF", instrF, mem_word(RESET_PC));
    drive();

    // Hold under stallF for three cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (validF) break;
      drive();
    end
    chk("second_valid", 32'(validF), 32'd1);
    s_pc = pcF;
    s_instr = instrF;
    stall_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      drive();
      @(negedge clk);
      chk("stall_valid", 32'(validF), 32'd1);
      chk("stall_pcF", pcF, s_pc);
      chk("stall_instrF", instrF, s_instr);
      chk("stall_no_req", 32'(inst_req), 32'd0);
    end
    drive();

    // Randomized traffic with branches, flushes, faults and stray data beats
    fast = 1'b0;
    quiet = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      drive();
    end
    quiet = 1'b1;
    fast = 1'b1;
    repeat (20) begin
      @(negedge clk);
      drive();
    end
    @(negedge clk);
    chk("enough_handoffs", 32'(n_ho >= 300), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
